rtc_alarm_clock: RTL and testbench
==================================

Name: rtc_alarm_clock

Overview:
Parametrised successor to the team's HH:MM:SS display clock. It adds an exact-period tick divider, edge-detected time setting, a 12/24-hour display mode, and an alarm register with a latched alarm output that clears on ack or timeout. The block drives the 7-segment digit decoders with BCD digits directly and exports a 1 Hz tick for other blocks.

Parameters:
DIV, 50_000_000, clk cycles per second tick (≥2); period is exactly DIV cycles.
ALARM_SECS, 60, seconds the alarm stays asserted without ack (1..255).

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
en  in  1  run enable; 0 freezes the divider and time, and setting still works
hrup  in  1  hour-advance button, already synchronised; acts on rising edge only
minup  in  1  minute-advance button, already synchronised; acts on rising edge only
alarm_set  in  1  1: hrup/minup edit the alarm time; 0: they edit the clock time
alarm_en  in  1  arms the alarm
alarm_ack  in  1  clears an active alarm (level, sampled each cycle)
mode12  in  1  1: 12-hour display; 0: 24-hour display
s1,s2,m1,m2,h1,h2  out  4 each  BCD ones/tens of seconds, minutes, hours (display view)
pm  out  1  1 when internal hour ≥12, in both modes
alarm  out  1  alarm active
sec_tick  out  1  one-cycle pulse on each second tick

Behaviour:
- Registered state: hour 0..23, min 0..59, sec 0..59, a_hour, a_min, divider counter, prev hrup/minup, alarm flag, alarm timer.
- Reset: all time, alarm-time and divider registers cleared. Outputs read 00:00:00 (in 12-h mode h2h1=12), pm=0, alarm=0, sec_tick=0.
- Priority each cycle: rst > everything else.
- Divider: runs only when en=1. When the counter equals DIV-1, it returns to 0 and the cycle is a tick. The register sec_tick=1 appears the following cycle for exactly 1 cycle. en=0 holds the counter value (no clear).
- Tick: sec+1. At 59, sec wraps to 0 and min carries. Min 59 wraps to 0 and hour carries. Hour 23 wraps to 0. 23:59:59 → 00:00:00.
- Edge detect: an edit fires on the cycle where input=1 and prev=0. A held button produces one increment only.
- Edit with alarm_set=0: minup edge sets min=(min+1) mod 60 and does not touch sec or hour. hrup edge sets hour=(hour+1) mod 24.
- Edit with alarm_set=1: the same arithmetic applies to a_min/a_hour, and clock time is untouched.
- Simultaneous clock edit and tick:
  - the tick still updates sec;
  - a carry into a field being edited that cycle is discarded, so the edit wins;
  - a carry into a non-edited field applies normally.
- Alarm trigger: occurs on a tick cycle whose resulting time is a_hour:a_min:00, with alarm_en=1. It sets alarm=1 and loads the timer with ALARM_SECS. Manual edits never trigger the alarm.
- Alarm clear: alarm_ack=1, alarm_en=0, or the timer reaching 0 clears alarm to 0 on the next edge. The timer decrements on each tick while alarm=1. If a trigger and alarm_ack arrive in the same cycle, ack wins.
- Display: digits are a combinational binary→BCD of the registers and are valid the cycle after the register update.
  - mode12=0: h = hour.
  - mode12=1: hour 0 → 12, 1..12 → same value, 13..23 → hour-12. pm is unaffected by mode.
  - mode12 changes the display only and never changes stored state.
- Reset mid-alarm or mid-edit: immediate clear. Prev-button registers reset to 0, so a button held through reset gives one edge after reset.

Test Plan:
- DIV=4, en=1 from reset: sec_tick pulses every 4 cycles. After 240 cycles min=1 (m1=1), sec=0.
- Preload 23:59:58 via edits and ticks, DIV=4: after 2 ticks the digits read 00:00:00 and pm goes 1→0.
- Hold minup high for 20 cycles with alarm_set=0: min increments by exactly 1. Release and press again: +1 more. A minup edge at min=59 gives 0 with hour unchanged.
- Clock at 06:59:59 with a minup edge in the tick cycle: result 06:00:00. The edit sets min to 0, the min carry into hour is dropped, and sec wraps.
- With alarm_set=1 set the alarm to 07:00, alarm_en=1, clock at 06:59:59: alarm=1 one cycle after the tick. With no ack, alarm falls after ALARM_SECS ticks. Repeat with alarm_ack pulsed 3 cycles later: alarm=0 on the next edge.
- mode12=1 at hour 0, 12, 13: h2h1 = 12/12/01 and pm = 0/1/1. Toggling mode12 leaves the internal hour unchanged, checked by toggling back.

Source files
------------

// File: rtl/rtc_alarm_clock_if.sv
// Control and display bundle for rtc_alarm_clock: buttons/modes in, BCD digits and status out.
interface rtc_alarm_clock_if;
    logic       en;
    logic       hrup;
    logic       minup;
    logic       alarm_set;
    logic       alarm_en;
    logic       alarm_ack;
    logic       mode12;
    logic [3:0] s1, s2, m1, m2, h1, h2;
    logic       pm;
    logic       alarm;
    logic       sec_tick;

    modport master (
        output en, hrup, minup, alarm_set, alarm_en, alarm_ack, mode12,
        input  s1, s2, m1, m2, h1, h2, pm, alarm, sec_tick
    );

    modport slave (
        input  en, hrup, minup, alarm_set, alarm_en, alarm_ack, mode12,
        output s1, s2, m1, m2, h1, h2, pm, alarm, sec_tick
    );
endinterface

// File: rtl/rtc_alarm_clock.sv
// HH:MM:SS clock with exact-period second divider, edge-triggered setting,
// 12/24-hour display and a latched alarm that clears on ack, disarm or timeout.
module rtc_alarm_clock #(
    parameter int DIV        = 50_000_000,
    parameter int ALARM_SECS = 60
) (
    input  logic              clk,
    input  logic              rst,
    rtc_alarm_clock_if.slave  bus
);
    localparam int            CW   = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    function automatic logic [5:0] inc60(input logic [5:0] v);
        return (v == 6'd59) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [4:0] inc24(input logic [4:0] v);
        return (v == 5'd23) ? 5'd0 : v + 5'd1;
    endfunction

    logic [CW-1:0] cnt;
    logic [4:0]    hours, a_hour, hours_n, hd;
    logic [5:0]    mins, secs, a_min, mins_n, secs_n;
    logic          hr_prev, min_prev, alarm_q, tick_q;
    logic [7:0]    timer;
    logic          tick, hr_edge, min_edge, c_hr_ed, c_min_ed;
    logic          sec_wrap, hr_carry, trigger;

    always_comb begin
        tick     = bus.en && (cnt == LAST);
        hr_edge  = bus.hrup && !hr_prev;
        min_edge = bus.minup && !min_prev;
        c_hr_ed  = hr_edge && !bus.alarm_set;
        c_min_ed = min_edge && !bus.alarm_set;
        sec_wrap = tick && (secs == 6'd59);
        secs_n   = tick ? inc60(secs) : secs;
        // An edit and a carry both mean +1, so the edit "winning" is a single increment.
        mins_n   = (c_min_ed || sec_wrap) ? inc60(mins) : mins;
        hr_carry = sec_wrap && (mins == 6'd59) && !c_min_ed;
        hours_n  = (c_hr_ed || hr_carry) ? inc24(hours) : hours;
        trigger  = tick && bus.alarm_en && (hours_n == a_hour) &&
                   (mins_n == a_min) && (secs_n == 6'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            hours    <= '0;
            mins     <= '0;
            secs     <= '0;
            a_hour   <= '0;
            a_min    <= '0;
            hr_prev  <= 1'b0;
            min_prev <= 1'b0;
            alarm_q  <= 1'b0;
            timer    <= '0;
            tick_q   <= 1'b0;
        end else begin
            if (bus.en) cnt <= tick ? '0 : cnt + CW'(1);
            tick_q   <= tick;
            hr_prev  <= bus.hrup;
            min_prev <= bus.minup;
            hours    <= hours_n;
            mins     <= mins_n;
            secs     <= secs_n;
            if (bus.alarm_set) begin
                if (hr_edge)  a_hour <= inc24(a_hour);
                if (min_edge) a_min  <= inc60(a_min);
            end
            // Timer hits zero on the last counted tick; alarm drops one edge later.
            if (bus.alarm_ack || !bus.alarm_en) begin
                alarm_q <= 1'b0;
            end else if (trigger) begin
                alarm_q <= 1'b1;
                timer   <= 8'(ALARM_SECS);
            end else if (alarm_q && timer == 8'd0) begin
                alarm_q <= 1'b0;
            end else if (alarm_q && tick) begin
                timer <= timer - 8'd1;
            end
        end
    end

    always_comb begin
        hd = hours;
        if (bus.mode12) begin
            if (hours == 5'd0)       hd = 5'd12;
            else if (hours > 5'd12)  hd = hours - 5'd12;
        end
    end

    assign bus.h2       = 4'(hd / 5'd10);
    assign bus.h1       = 4'(hd % 5'd10);
    assign bus.m2       = 4'(mins / 6'd10);
    assign bus.m1       = 4'(mins % 6'd10);
    assign bus.s2       = 4'(secs / 6'd10);
    assign bus.s1       = 4'(secs % 6'd10);
    assign bus.pm       = (hours >= 5'd12);
    assign bus.alarm    = alarm_q;
    assign bus.sec_tick = tick_q;
endmodule

// File: tb/tb_rtc_alarm_clock.sv
// Randomized and directed bench for rtc_alarm_clock against a seconds-of-day reference model.
module tb_rtc_alarm_clock;
    localparam int DIV        = 4;
    localparam int ALARM_SECS = 5;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    rtc_alarm_clock_if bus();

    rtc_alarm_clock #(.DIV(DIV), .ALARM_SECS(ALARM_SECS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // reference model state
    int mh = 0, mm = 0, ms = 0, ah = 0, am = 0, mcnt = 0, since = 0;
    bit ph = 0, pmn = 0, mal = 0, mtk = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [26:0] exp_vec();
        int hd;
        hd = bus.mode12 ? ((mh % 12 == 0) ? 12 : mh % 12) : mh;
        return {4'(hd / 10), 4'(hd % 10), 4'(mm / 10), 4'(mm % 10),
                4'(ms / 10), 4'(ms % 10), 1'(mh >= 12), mal, mtk};
    endfunction

    function automatic logic [26:0] dut_vec();
        return {bus.h2, bus.h1, bus.m2, bus.m1, bus.s2, bus.s1, bus.pm, bus.alarm, bus.sec_tick};
    endfunction

    // One clock: predict from pre-edge inputs, advance, compare everything.
    task automatic cyc();
        bit tk, eh, em, tr, nal, ntk, nph, npm;
        int nh, nm, ns, t, nah, nam, ncnt, nsince;
        nh = mh; nm = mm; ns = ms; nah = ah; nam = am; ncnt = mcnt;
        nal = mal; nsince = since; ntk = 0; nph = bus.hrup; npm = bus.minup;
        if (rst) begin
            nh = 0; nm = 0; ns = 0; nah = 0; nam = 0; ncnt = 0;
            nal = 0; nsince = 0; nph = 0; npm = 0;
        end else begin
            tk = bus.en && (mcnt == DIV - 1);
            eh = bus.hrup && !ph;
            em = bus.minup && !pmn;
            if (tk) begin
                t  = (mh * 3600 + mm * 60 + ms + 1) % 86400;
                nh = t / 3600; nm = (t / 60) % 60; ns = t % 60;
            end
            if (!bus.alarm_set && em) begin
                nm = (mm + 1) % 60;
                nh = mh;
            end
            if (!bus.alarm_set && eh) nh = (mh + 1) % 24;
            if (bus.alarm_set && eh) nah = (ah + 1) % 24;
            if (bus.alarm_set && em) nam = (am + 1) % 60;
            tr = tk && bus.alarm_en && nh == ah && nm == am && ns == 0;
            if (bus.alarm_ack || !bus.alarm_en) nal = 0;
            else if (tr) begin nal = 1; nsince = 0; end
            else if (mal && since == ALARM_SECS) nal = 0;
            else if (mal && tk) nsince = since + 1;
            if (bus.en) ncnt = tk ? 0 : mcnt + 1;
            ntk = tk;
        end
        @(posedge clk);
        #1;
        mh = nh; mm = nm; ms = ns; ah = nah; am = nam; mcnt = ncnt;
        mal = nal; since = nsince; mtk = ntk; ph = nph; pmn = npm;
        chk("cyc", 32'(dut_vec()), 32'(exp_vec()));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic press_h(input int n);
        for (int i = 0; i < n; i++) begin
            bus.hrup = 1'b1; cyc();
            bus.hrup = 1'b0; cyc();
        end
    endtask

    task automatic press_m(input int n);
        for (int i = 0; i < n; i++) begin
            bus.minup = 1'b1; cyc();
            bus.minup = 1'b0; cyc();
        end
    endtask

    task automatic run_to(input int h, input int m, input int s);
        int n;
        n = 0;
        bus.en = 1'b1;
        while (!(mh == h && mm == m && ms == s) && n < 20000) begin
            cyc();
            n++;
        end
        chk("reach", 32'(n < 20000), 32'd1);
    endtask

    task automatic alarm_setup();
        do_reset();
        bus.en = 1'b0; bus.alarm_en = 1'b0;
        bus.alarm_set = 1'b1; press_h(7);
        bus.alarm_set = 1'b0; press_h(6); press_m(59);
        bus.alarm_en = 1'b1;
        run_to(6, 59, 59);
        for (int i = 0; i < 50 && !bus.alarm; i++) cyc();
        chk("alarm_rise", 32'({bus.alarm, bus.sec_tick}), 32'b11);
        chk("alarm_time", 32'({bus.h2, bus.h1, bus.m2, bus.m1, bus.s2, bus.s1}), 32'h070000);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        bus.en = 0; bus.hrup = 0; bus.minup = 0; bus.alarm_set = 0;
        bus.alarm_en = 0; bus.alarm_ack = 0; bus.mode12 = 0;
        do_reset();
        chk("rst_digits", 32'({bus.h2, bus.h1, bus.m2, bus.m1, bus.s2, bus.s1}), 32'h0);
        chk("rst_flags", 32'({bus.pm, bus.alarm, bus.sec_tick}), 32'h0);
        bus.mode12 = 1'b1; #1;
        chk("rst_h12", 32'({bus.h2, bus.h1}), 32'h12);
        bus.mode12 = 1'b0;

        // free run: 240 cycles = 60 ticks
        bus.en = 1'b1;
        n = 0;
        for (int i = 0; i < 240; i++) begin
            cyc();
            if (bus.sec_tick) n++;
        end
        chk("tick_count", 32'(n), 32'd60);
        chk("min_240", 32'({bus.m2, bus.m1, bus.s2, bus.s1}), 32'h0100);

        // midnight rollover
        do_reset();
        bus.en = 1'b0;
        press_h(23); press_m(59);
        run_to(23, 59, 58);
        run_to(23, 59, 59);
        chk("pm_before", 32'(bus.pm), 32'd1);
        run_to(0, 0, 0);
        chk("midnight", 32'({bus.h2, bus.h1, bus.m2, bus.m1, bus.s2, bus.s1}), 32'h0);
        chk("pm_after", 32'(bus.pm), 32'd0);

        // held button gives one increment; minute wrap leaves hour alone
        do_reset();
        bus.en = 1'b0;
        bus.minup = 1'b1;
        repeat (20) cyc();
        bus.minup = 1'b0; cyc();
        chk("hold_once", 32'({bus.m2, bus.m1}), 32'h01);
        press_m(1);
        chk("press_again", 32'({bus.m2, bus.m1}), 32'h02);
        press_h(3); press_m(57);
        press_m(1);
        chk("min_wrap", 32'({bus.h2, bus.h1, bus.m2, bus.m1}), 32'h0300);

        // minute edit during the carrying tick
        do_reset();
        bus.en = 1'b0;
        press_h(6); press_m(59);
        run_to(6, 59, 59);
        n = 0;
        while (mcnt != DIV - 1 && n < 10) begin cyc(); n++; end
        bus.minup = 1'b1; cyc(); bus.minup = 1'b0;
        chk("edit_tick", 32'({bus.h2, bus.h1, bus.m2, bus.m1, bus.s2, bus.s1}), 32'h060000);

        // alarm timeout
        alarm_setup();
        n = 0;
        for (int i = 0; i < 1000 && bus.alarm; i++) begin
            cyc();
            if (bus.alarm && bus.sec_tick) n++;
        end
        chk("alarm_fall", 32'(bus.alarm), 32'd0);
        chk("alarm_len", 32'(n), 32'(ALARM_SECS));

        // alarm ack
        alarm_setup();
        repeat (3) cyc();
        chk("alarm_hold", 32'(bus.alarm), 32'd1);
        bus.alarm_ack = 1'b1; cyc(); bus.alarm_ack = 1'b0;
        chk("ack_clear", 32'(bus.alarm), 32'd0);

        // 12-hour display
        do_reset();
        bus.en = 1'b0; bus.alarm_en = 1'b0; bus.mode12 = 1'b1; #1;
        chk("h12_0", 32'({bus.h2, bus.h1, bus.pm}), 32'({8'h12, 1'b0}));
        press_h(12);
        chk("h12_12", 32'({bus.h2, bus.h1, bus.pm}), 32'({8'h12, 1'b1}));
        press_h(1);
        chk("h12_13", 32'({bus.h2, bus.h1, bus.pm}), 32'({8'h01, 1'b1}));
        bus.mode12 = 1'b0; #1;
        chk("h24_13", 32'({bus.h2, bus.h1}), 32'h13);

        // random mix
        bus.alarm_en = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            rst           = ($urandom_range(0, 599) == 0);
            bus.en        = ($urandom_range(0, 9) != 0);
            bus.hrup      = ($urandom_range(0, 15) == 0) ? ~bus.hrup : bus.hrup;
            bus.minup     = ($urandom_range(0, 7) == 0) ? ~bus.minup : bus.minup;
            bus.alarm_set = ($urandom_range(0, 63) == 0) ? ~bus.alarm_set : bus.alarm_set;
            bus.alarm_en  = ($urandom_range(0, 99) != 0);
            bus.alarm_ack = ($urandom_range(0, 49) == 0);
            bus.mode12    = ($urandom_range(0, 31) == 0) ? ~bus.mode12 : bus.mode12;
            cyc();
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
